// File: rtl/servo_pkg.sv
// Shared definitions for the servo channels: FSM state encoding, default timing
// constants and the pulse-width clamp helper.
package servo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } servo_state_e;

  localparam int unsigned PERIOD_DEF   = 2000000;
  localparam int unsigned D_MIN_DEF    = 50000;
  localparam int unsigned D_MAX_DEF    = 250000;
  localparam int unsigned STEP_DEF_DEF = 1000;

  // Operates on a 64-bit container so any channel width up to 64 can share it.
  function automatic logic [63:0] clamp(input logic [63:0] v,
                                        input logic [63:0] lo,
                                        input logic [63:0] hi);
    logic [63:0] r;
    r = v;
    if (v < lo) r = lo;
    else if (v > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/servo_ramp_if.sv
// Command channel into a servo ramp stage.
// Handshake: a command transfers on every clk edge where cmd_valid && cmd_ready;
// the master holds cmd_target/cmd_step stable while cmd_valid is high and not yet accepted.
interface servo_ramp_if #(
  parameter int W = 32
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_target;
  logic [W-1:0] cmd_step;

  modport master (
    output cmd_valid,
    output cmd_target,
    output cmd_step,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  cmd_step,
    output cmd_ready
  );
endinterface

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter 0..PERIOD-1; frame is high on the last count.
module servo_frame_timer #(
  parameter int unsigned PERIOD = servo_pkg::PERIOD_DEF
) (
  input  logic clk,
  input  logic res_n,
  output logic frame
);
  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!res_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign frame = (cnt == LAST);

endmodule

// File: rtl/servo_ramp.sv
// Servo motion-profile stage: slews d toward the commanded pulse width by at most
// one step per PWM frame. Define SERVO_RAMP_RETARGET_EN to accept new commands mid-ramp.
module servo_ramp
  import servo_pkg::*;
#(
  parameter int          W        = 32,
  parameter int unsigned PERIOD   = PERIOD_DEF,
  parameter int unsigned D_MIN    = D_MIN_DEF,
  parameter int unsigned D_MAX    = D_MAX_DEF,
  parameter int unsigned STEP_DEF = STEP_DEF_DEF
) (
  input  logic          clk,
  input  logic          res_n,
  servo_ramp_if.slave   cmd,
  output logic [W-1:0]  d,
  output logic [W-1:0]  t,
  output logic          pwm_en,
  output logic          busy,
  output logic          done,
  output logic          frame,
  output servo_state_e  dbg_state
);

  localparam logic [W-1:0] D_MID = W'((D_MIN + D_MAX) / 2);

  servo_state_e state;
  logic [W-1:0] target_q;
  logic [W-1:0] step_q;

  logic [W-1:0] in_target;
  logic [W-1:0] in_step;
  logic         hs;
  logic         in_at_d;
  logic [W:0]   diff;
  logic [W:0]   mag;
  logic         near;
  logic [W-1:0] d_step;

  servo_frame_timer #(.PERIOD(PERIOD)) u_timer (
    .clk   (clk),
    .res_n (res_n),
    .frame (frame)
  );

  assign t         = W'(PERIOD);
  assign dbg_state = state;

  // Difference carried at W+1 bits so the sign survives and |diff| never wraps.
  always_comb begin
    in_target = W'(clamp(64'(cmd.cmd_target), 64'(D_MIN), 64'(D_MAX)));
    in_step   = (cmd.cmd_step == '0) ? W'(STEP_DEF) : cmd.cmd_step;
    hs        = cmd.cmd_valid && cmd.cmd_ready;
    in_at_d   = (in_target == d);
    diff      = {1'b0, target_q} - {1'b0, d};
    mag       = diff[W] ? (~diff + {{W{1'b0}}, 1'b1}) : diff;
    near      = (mag <= {1'b0, step_q});
    d_step    = diff[W] ? (d - step_q) : (d + step_q);
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state         <= ST_IDLE;
      d             <= D_MID;
      target_q      <= D_MID;
      step_q        <= W'(STEP_DEF);
      pwm_en        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cmd.cmd_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (hs) begin
            target_q <= in_target;
            step_q   <= in_step;
            pwm_en   <= 1'b1;
            if (in_at_d) begin
              state         <= ST_DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b0;
            end else begin
              state <= ST_RAMP;
              busy  <= 1'b1;
`ifdef SERVO_RAMP_RETARGET_EN
              cmd.cmd_ready <= 1'b1;
`else
              cmd.cmd_ready <= 1'b0;
`endif
            end
          end
        end

        ST_RAMP: begin
`ifdef SERVO_RAMP_RETARGET_EN
          // A new command wins over a coincident frame; stepping resumes next frame.
          if (hs) begin
            target_q <= in_target;
            step_q   <= in_step;
            if (in_at_d) begin
              state         <= ST_DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b0;
            end
          end else
`endif
          if (frame) begin
            if (near) begin
              d             <= target_q;
              state         <= ST_DONE;
              done          <= 1'b1;
              busy          <= 1'b0;
              cmd.cmd_ready <= 1'b0;
            end else begin
              d <= d_step;
            end
          end
        end

        ST_DONE: begin
          done          <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= ST_IDLE;
        end

        default: begin
          state         <= ST_IDLE;
          done          <= 1'b0;
          busy          <= 1'b0;
          cmd.cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/servo_ramp.md
# servo_ramp

Motion-profile stage feeding the servo PWM generator. Accepts a target pulse width per servo command over a valid/ready handshake. Slews the duty output `d` toward that target by a bounded step once per PWM period, so a servo never sees a position jump. Drives the generator's `d`, `t` and `enable` inputs directly and reports completion to the LM32 Wishbone register block.

## Interface
- `W`, 32: width of all count and duty values.
- `PERIOD`, 2000000: PWM frame length in clk cycles (20 ms at 100 MHz). Driven on `t`.
- `D_MIN`, 50000: minimum legal pulse width (0.5 ms).
- `D_MAX`, 250000: maximum legal pulse width (2.5 ms).
- `STEP_DEF`, 1000: step used when `cmd_step` is 0.

- `clk` in 1: system clock.
- `res_n` in 1: reset, synchronous and active-low.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_target` in W: requested pulse width in clk cycles.
- `cmd_step` in W: maximum change of `d` per frame.
- `d` out W: current pulse width, to the PWM generator.
- `t` out W: period, constant `PERIOD`.
- `pwm_en` out 1: enable to the PWM generator.
- `busy` out 1: a ramp is in progress.
- `done` out 1: one-cycle pulse when `d` reaches the target.
- `frame` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Reset values, applied while `res_n`=0 at a clk edge:
  - `d` = (D_MIN+D_MAX)/2.
  - `t` = PERIOD.
  - `pwm_en`=0, `busy`=0, `done`=0, `frame`=0.
  - Frame counter = 0.
  - `cmd_ready`=1 after reset.
- Frame counter runs freely 0..PERIOD-1 and wraps to 0. `frame`=1 when the count is PERIOD-1.
- FSM states:
  - IDLE: `cmd_ready`=1. On handshake (`cmd_valid`&&`cmd_ready`):
    - latch target = clamp(`cmd_target`, D_MIN, D_MAX);
    - latch step = (`cmd_step`==0 ? STEP_DEF : `cmd_step`);
    - set `pwm_en`=1, which then stays 1 until reset;
    - go to DONE if target==`d`, else go to RAMP.
  - RAMP: `busy`=1, `cmd_ready`=0. On each `frame` cycle:
    - if |target−`d`| <= step, then `d` <= target and go to DONE;
    - else `d` <= `d` ± step, moving toward target.
  - DONE: `done`=1 for one cycle, `busy`=0, then go to IDLE.
- Arithmetic: compute the difference at W+1 bits so the comparison does not wrap. `d` never overshoots the target and never leaves [D_MIN, D_MAX].
- `d` changes only in a `frame` cycle, so each pulse width is held for a full period.
- Reset mid-ramp discards the target and restores the reset values immediately.

## Timing
- Handshake completes in the cycle with `cmd_valid`&&`cmd_ready`. `busy` is high from the next cycle.
- Target==`d`: `done` pulses on the cycle after the handshake, with no frame wait.
- Ramp of N steps: `d` updates on the edge ending each of the next N `frame` cycles. `done` pulses on the cycle after the final update.
- `cmd_valid` may be held. While `cmd_ready`=0 the command is not consumed.
- `t` is constant after reset. `frame` is independent of the FSM.

## Configuration
- `SERVO_RAMP_RETARGET_EN` defined:
  - `cmd_ready`=1 in RAMP as well as IDLE.
  - A handshake in RAMP replaces target and step. The ramp continues from the current `d` at the next `frame`.
  - No `done` pulse is issued for the abandoned target.
  - A retarget to a value equal to `d` goes to DONE on the next cycle.
- Not defined: `cmd_ready`=0 in RAMP and DONE. Commands wait until IDLE.

## Structure
- Shared package `servo_pkg` holds:
  - the FSM state enum (IDLE, RAMP, DONE);
  - default constants for PERIOD, D_MIN, D_MAX and STEP_DEF;
  - the `clamp` function.
- Sub-module `servo_frame_timer` contains the PERIOD counter and the `frame` pulse, with parameter PERIOD. Reused by the other servo channels.

## Test plan
Bench parameters: PERIOD=100, D_MIN=10, D_MAX=50, STEP_DEF=5. Reset value of `d` is 30.
- Reset: hold `res_n`=0 for 3 cycles, then release.
  - Required: `d`=30, `t`=100, `pwm_en`=0, `cmd_ready`=1, `busy`=0.
  - First `frame` pulse 99 cycles after release.
- Ramp up: target=40, step=4.
  - Required: `d` goes 30→34→38→40 on 3 consecutive frames.
  - Single `done` pulse on the cycle after the third update; `busy` low afterwards.
- Clamp and default step: target=80, step=0.
  - Required: `d` goes 30→35→40→45→50 over 4 frames; `d` never exceeds 50.
- Zero-distance command: target=30.
  - Required: `done` pulses 1 cycle after the handshake; `d` unchanged; `pwm_en`=1.
- Reset mid-ramp: drive `res_n`=0 while `d`=38 during a ramp to 50.
  - Required: next cycle `d`=30, `busy`=0, `pwm_en`=0; no `done` pulse.
- Retarget, with `SERVO_RAMP_RETARGET_EN`: during a ramp to 50 at `d`=40, issue target=10, step=10.
  - Required: `d` goes 30, 20, 10 on the next 3 frames, then exactly one `done` pulse.
  - Without the macro: `cmd_ready`=0 during the ramp, and the command is accepted only after the first `done`.
